// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: bus widths, reset vector, FSM encoding.
package fetch_unit_pkg;

   localparam int          ADDR_BUS     = 32;
   localparam int          INST_BUS     = 32;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_OUT  = 2'd2,
      FETCH_DROP = 2'd3
   } fetch_state_e;

   // True when a fetch address is not word aligned
   function automatic logic addr_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: exception redirect, then branch target, then sequential.
module fetch_pc_sel #(
   parameter int ADDR_W = 32
) (
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              pending_br_i,
   input  logic [ADDR_W-1:0] pend_addr_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] next_pc_o
);

   // Redirect beats branch; sequential step wraps naturally at the word width
   always_comb begin
      if (flush_i) begin
         next_pc_o = flush_pc_i;
      end else if (pending_br_i) begin
         next_pc_o = pend_addr_i;
      end else begin
         next_pc_o = pc_i + ADDR_W'(4);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, single-outstanding word fetch, and IF/ID output register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   flush_pc,
   input  logic                branch_flag,
   input  logic [ADDR_W-1:0]   branch_addr,
   output logic                inst_req,
   output logic [ADDR_W-1:0]   inst_addr,
   input  logic                inst_gnt,
   input  logic                inst_rvalid,
   input  logic [INST_BUS-1:0] inst_rdata,
   output logic                if_valid,
   output logic [ADDR_W-1:0]   if_pc,
   output logic [INST_BUS-1:0] if_inst,
   output logic                if_adel
);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d, next_pc;
   logic                run_q;
   logic                if_valid_q;
   logic [ADDR_W-1:0]   if_pc_q;
   logic [INST_BUS-1:0] if_inst_q;
   logic                if_adel_q;
   logic                id_fire;
   logic                pending_br;
   logic                pc_bad;
   logic                req_active;

   assign id_fire    = if_valid_q & ~stall;
   assign pc_bad     = addr_misaligned(pc_q[1:0]);
   assign req_active = run_q & (state_q == FETCH_REQ) & ~pc_bad;

   // A branch taken as the delay slot leaves IF: the slot is already fetched,
   // so the target is consumed on this very edge rather than held over
   assign pending_br = id_fire & branch_flag;

   fetch_pc_sel #(.ADDR_W(ADDR_W)) u_pc_sel (
      .flush_i      (flush),
      .flush_pc_i   (flush_pc),
      .pending_br_i (pending_br),
      .pend_addr_i  (branch_addr),
      .pc_i         (pc_q),
      .next_pc_o    (next_pc)
   );

   // PC only moves when ID takes the instruction or a redirect arrives
   always_comb begin
      pc_d = pc_q;
      if (flush || id_fire) begin
         pc_d = next_pc;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; flush overrides every other transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_REQ: begin
            if (run_q) begin
               if (flush) begin
                  state_d = (inst_gnt && !pc_bad) ? FETCH_DROP : FETCH_REQ;
               end else if (pc_bad) begin
                  state_d = FETCH_OUT;
               end else if (inst_gnt) begin
                  state_d = FETCH_WAIT;
               end
            end
         end
         FETCH_WAIT: begin
            if (flush) begin
               state_d = inst_rvalid ? FETCH_REQ : FETCH_DROP;
            end else if (inst_rvalid) begin
               state_d = FETCH_OUT;
            end
         end
         FETCH_OUT: begin
            if (flush || id_fire) begin
               state_d = FETCH_REQ;
            end
         end
         FETCH_DROP: begin
            if (inst_rvalid) begin
               state_d = FETCH_REQ;
            end
         end
         default: state_d = FETCH_REQ;
      endcase
   end

   // FSM outputs: request held from assertion until grant, address is the PC
   always_comb begin
      inst_req  = req_active;
      inst_addr = pc_q;
   end

   // PC, start-up gate and IF/ID output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         run_q      <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
         if_adel_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         pc_q  <= pc_d;
         if (flush) begin
            if_valid_q <= 1'b0;
         end else if (state_q == FETCH_WAIT && inst_rvalid) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            if_inst_q  <= inst_rdata;
            if_adel_q  <= 1'b0;
         end else if (run_q && state_q == FETCH_REQ && pc_bad) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            if_inst_q  <= '0;
            if_adel_q  <= 1'b1;
         end else if (id_fire) begin
            if_valid_q <= 1'b0;
         end
      end
   end

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_inst  = if_inst_q;
   assign if_adel  = if_adel_q;

endmodule
